// File: rtl/cdb_arbiter_if.sv
// Handshake/bus bundle between the functional units, the CDB arbiter and the CDB mux.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

interface cdb_arbiter_if #(
  parameter int FU_NUM = 4
);
  logic                                  flush;
  logic [FU_NUM-1:0]                     fu_valid;
  logic [FU_NUM-1:0][`XLEN-1:0]          fu_value;
  logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0]   fu_rob_tag;
  logic [FU_NUM-1:0]                     fu_ready;
  logic [FU_NUM-1:0][`XLEN-1:0]          out_values;
  logic                                  select_flag;
  logic [$clog2(FU_NUM)-1:0]             select_signal;
  logic [`ROB_TAG_LEN-1:0]               ROB_tag;

  modport master (
    output flush, fu_valid, fu_value, fu_rob_tag,
    input  fu_ready, out_values, select_flag, select_signal, ROB_tag
  );

  modport slave (
    input  flush, fu_valid, fu_value, fu_rob_tag,
    output fu_ready, out_values, select_flag, select_signal, ROB_tag
  );
endinterface

// File: rtl/cdb_arbiter.sv
// One-deep result buffer per FU with round-robin grant onto the common data bus.
// Define CDB_FIXED_PRIORITY_EN for lowest-index-wins arbitration (no rotating pointer).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module cdb_arbiter #(
  parameter int FU_NUM = 4
) (
  input logic             clock,
  input logic             reset,
  cdb_arbiter_if.slave    bus
);
  localparam int          SW = $clog2(FU_NUM);
  localparam int unsigned N  = FU_NUM;

  logic [FU_NUM-1:0]                   r_hold_valid;
  logic [FU_NUM-1:0][`XLEN-1:0]        r_hold_value;
  logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0] r_hold_tag;

  logic [FU_NUM-1:0] w_grant;
  logic [FU_NUM-1:0] w_ready;
  logic [SW-1:0]     w_win;
  logic              w_any;
  int unsigned       w_start;

`ifdef CDB_FIXED_PRIORITY_EN
  assign w_start = 0;
`else
  logic [SW-1:0] r_ptr;
  assign w_start = int'(r_ptr);
`endif

  always_comb begin
    int unsigned idx;
    idx     = 0;
    w_any   = 1'b0;
    w_win   = '0;
    w_grant = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = w_start + off;
      if (idx >= N) idx = idx - N;
      if (!w_any && r_hold_valid[idx]) begin
        w_any = 1'b1;
        w_win = SW'(idx);
      end
    end
    // A flush squashes the pending grant along with everything buffered.
    if (bus.flush) w_any = 1'b0;
    if (w_any) w_grant[w_win] = 1'b1;
  end

  assign w_ready           = bus.flush ? '0 : (~r_hold_valid | w_grant);
  assign bus.fu_ready      = w_ready;
  assign bus.out_values    = r_hold_value;
  assign bus.select_flag   = w_any;
  assign bus.select_signal = w_any ? w_win : '0;
  assign bus.ROB_tag       = w_any ? r_hold_tag[w_win] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold_valid <= '0;
      r_hold_value <= '0;
      r_hold_tag   <= '0;
`ifndef CDB_FIXED_PRIORITY_EN
      r_ptr        <= '0;
`endif
    end else if (bus.flush) begin
      r_hold_valid <= '0;
`ifndef CDB_FIXED_PRIORITY_EN
      r_ptr        <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (bus.fu_valid[i] && w_ready[i]) begin
          r_hold_valid[i] <= 1'b1;
          r_hold_value[i] <= bus.fu_value[i];
          r_hold_tag[i]   <= bus.fu_rob_tag[i];
        end else if (w_grant[i]) begin
          r_hold_valid[i] <= 1'b0;
        end
      end
`ifndef CDB_FIXED_PRIORITY_EN
      if (w_any) begin
        if (w_win == SW'(FU_NUM - 1)) r_ptr <= '0;
        else                          r_ptr <= w_win + 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Table-driven bench for cdb_arbiter (round-robin build) with a per-cycle expectation queue.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TL = `ROB_TAG_LEN;
  localparam int XL = `XLEN;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cdb_arbiter_if #(.FU_NUM(N)) bus();
  cdb_arbiter #(.FU_NUM(N)) dut (.clock(clock), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic                  flush;
    logic [N-1:0]          fv;
    logic [N-1:0][XL-1:0]  val;
    logic [N-1:0][TL-1:0]  tag;
    logic                  e_flag;
    logic [1:0]            e_sel;
    logic [TL-1:0]         e_tag;
    logic [N-1:0]          e_ready;
    logic [XL-1:0]         e_val;
  } vec_t;

  typedef struct {
    int            row;
    logic          e_flag;
    logic [1:0]    e_sel;
    logic [TL-1:0] e_tag;
    logic [N-1:0]  e_ready;
    logic [XL-1:0] e_val;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic logic [XL-1:0] vval(int i, int t);
    return 32'hC0DE_0000 | XL'(i << 8) | XL'(t);
  endfunction

  function automatic vec_t mk(logic fl, logic [N-1:0] fv, int t0, int t1, int t2, int t3,
                              logic [XL-1:0] xval, logic ef, int es, int et,
                              logic [N-1:0] er, logic [XL-1:0] ev);
    vec_t v;
    int   t[N];
    t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
    v.flush = fl;
    v.fv    = fv;
    for (int i = 0; i < N; i++) begin
      v.tag[i] = TL'(t[i]);
      v.val[i] = (xval != '0) ? xval : vval(i, t[i]);
    end
    v.e_flag  = ef;
    v.e_sel   = 2'(es);
    v.e_tag   = TL'(et);
    v.e_ready = er;
    v.e_val   = ev;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic fl, logic [N-1:0] fv, logic [N-1:0][XL-1:0] val,
                       logic [N-1:0][TL-1:0] tag);
    bus.flush      = fl;
    bus.fu_valid   = fv;
    bus.fu_value   = val;
    bus.fu_rob_tag = tag;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    // Contention, ptr=0: grants 0,1,2,3
    tbl.push_back(mk(0, 4'b1111, 10, 11, 12, 13, '0, 0, 0, 0, 4'b1111, '0));
    tbl.push_back(mk(0, 4'b0000,  0,  0,  0,  0, '0, 1, 0, 10, 4'b0001, vval(0, 10)));
    tbl.push_back(mk(0, 4'b0000,  0,  0,  0,  0, '0, 1, 1, 11, 4'b0011, vval(1, 11)));
    tbl.push_back(mk(0, 4'b0000,  0,  0,  0,  0, '0, 1, 2, 12, 4'b0111, vval(2, 12)));
    tbl.push_back(mk(0, 4'b0000,  0,  0,  0,  0, '0, 1, 3, 13, 4'b1111, vval(3, 13)));
    // Single result on FU2, ptr moves to 3
    tbl.push_back(mk(0, 4'b0100,  0,  0,  5,  0, 32'hDEAD_BEEF, 0, 0, 0, 4'b1111, '0));
    tbl.push_back(mk(0, 4'b0000,  0,  0,  0,  0, '0, 1, 2, 5, 4'b1111, 32'hDEAD_BEEF));
    // Wrap: ptr=3, slots 0 and 3 -> 3 then 0, ptr ends at 1
    tbl.push_back(mk(0, 4'b1001, 20,  0,  0, 21, '0, 0, 0, 0, 4'b1111, '0));
    tbl.push_back(mk(0, 4'b0000,  0,  0,  0,  0, '0, 1, 3, 21, 4'b1110, vval(3, 21)));
    tbl.push_back(mk(0, 4'b0000,  0,  0,  0,  0, '0, 1, 0, 20, 4'b1111, vval(0, 20)));
    // ptr=1 check: slots 0 and 1 -> 1 then 0
    tbl.push_back(mk(0, 4'b0011, 22, 23,  0,  0, '0, 0, 0, 0, 4'b1111, '0));
    tbl.push_back(mk(0, 4'b0000,  0,  0,  0,  0, '0, 1, 1, 23, 4'b1110, vval(1, 23)));
    tbl.push_back(mk(0, 4'b0000,  0,  0,  0,  0, '0, 1, 0, 22, 4'b1111, vval(0, 22)));
    // Back-to-back refill on FU1
    tbl.push_back(mk(0, 4'b0010,  0,  1,  0,  0, '0, 0, 0, 0, 4'b1111, '0));
    tbl.push_back(mk(0, 4'b0010,  0,  2,  0,  0, '0, 1, 1, 1, 4'b1111, vval(1, 1)));
    tbl.push_back(mk(0, 4'b0010,  0,  3,  0,  0, '0, 1, 1, 2, 4'b1111, vval(1, 2)));
    tbl.push_back(mk(0, 4'b0000,  0,  0,  0,  0, '0, 1, 1, 3, 4'b1111, vval(1, 3)));
    tbl.push_back(mk(0, 4'b0000,  0,  0,  0,  0, '0, 0, 0, 0, 4'b1111, '0));
    // Flush with slots 0,2 full and FU1 presenting
    tbl.push_back(mk(0, 4'b0101, 30,  0, 31,  0, '0, 0, 0, 0, 4'b1111, '0));
    tbl.push_back(mk(1, 4'b0010,  0, 32,  0,  0, '0, 0, 0, 0, 4'b0000, '0));
    tbl.push_back(mk(0, 4'b0000,  0,  0,  0,  0, '0, 0, 0, 0, 4'b1111, '0));
    // ptr reset to 0 by flush: slots 1 and 3 -> 1 then 3
    tbl.push_back(mk(0, 4'b1010,  0, 40,  0, 41, '0, 0, 0, 0, 4'b1111, '0));
    tbl.push_back(mk(0, 4'b0000,  0,  0,  0,  0, '0, 1, 1, 40, 4'b0111, vval(1, 40)));
    tbl.push_back(mk(0, 4'b0000,  0,  0,  0,  0, '0, 1, 3, 41, 4'b1111, vval(3, 41)));
    tbl.push_back(mk(0, 4'b0000,  0,  0,  0,  0, '0, 0, 0, 0, 4'b1111, '0));

    drive(1'b0, '0, '0, '0);
    #2;
    chk("rst_flag",  64'(bus.select_flag), 64'd0);
    chk("rst_ready", 64'(bus.fu_ready), 64'hF);
    chk("rst_outv",  64'(bus.out_values == '0), 64'd1);
    @(negedge clock);
    reset = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clock);
      drive(tbl[k].flush, tbl[k].fv, tbl[k].val, tbl[k].tag);
      sb.push_back('{k, tbl[k].e_flag, tbl[k].e_sel, tbl[k].e_tag, tbl[k].e_ready, tbl[k].e_val});
      #1;
      if (sb.size() == 0) begin
        chk("sb_empty", 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("r%0d_flag", e.row),  64'(bus.select_flag),   64'(e.e_flag));
        chk($sformatf("r%0d_sel", e.row),   64'(bus.select_signal), 64'(e.e_sel));
        chk($sformatf("r%0d_tag", e.row),   64'(bus.ROB_tag),       64'(e.e_tag));
        chk($sformatf("r%0d_ready", e.row), 64'(bus.fu_ready),      64'(e.e_ready));
        if (e.e_flag)
          chk($sformatf("r%0d_val", e.row), 64'(bus.out_values[e.e_sel]), 64'(e.e_val));
      end
    end

    // Asynchronous reset mid-operation with slots 1 and 2 full
    @(negedge clock);
    drive(1'b0, 4'b0110, {vval(3, 0), vval(2, 51), vval(1, 50), vval(0, 0)},
          {TL'(0), TL'(51), TL'(50), TL'(0)});
    @(negedge clock);
    drive(1'b0, '0, '0, '0);
    #1;
    chk("mid_flag_pre", 64'(bus.select_flag), 64'd1);
    chk("mid_sel_pre",  64'(bus.select_signal), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_flag",  64'(bus.select_flag),   64'd0);
    chk("mid_sel",   64'(bus.select_signal), 64'd0);
    chk("mid_tag",   64'(bus.ROB_tag),       64'd0);
    chk("mid_ready", 64'(bus.fu_ready),      64'hF);
    chk("mid_outv",  64'(bus.out_values == '0), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 4'b0001, {vval(3, 0), vval(2, 0), vval(1, 0), vval(0, 60)},
          {TL'(0), TL'(0), TL'(0), TL'(60)});
    #1;
    chk("post_flag", 64'(bus.select_flag), 64'd0);
    @(negedge clock);
    drive(1'b0, '0, '0, '0);
    #1;
    chk("post_grant_flag", 64'(bus.select_flag), 64'd1);
    chk("post_grant_tag",  64'(bus.ROB_tag), 64'd60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
